// File: rtl/int_sync_crossing_source.sv
// Transmit end of the interrupt sync-crossing: synchronises raw interrupt lines, passes
// level lines through and stretches edge lines. Optional glitch filter: INT_SYNC_SRC_FILTER_EN.
module int_sync_crossing_source #(
  parameter int                   NUM_INT       = 4,
  parameter int                   SYNC_STAGES   = 2,
  parameter logic [NUM_INT-1:0]   EDGE_MASK     = '0,
  parameter int                   PULSE_CYCLES  = 4,
  parameter int                   FILTER_CYCLES = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_INT-1:0] auto_in,
  output logic [NUM_INT-1:0] auto_out_sync,
  output logic               busy
);

  localparam int            CW         = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES);

  // Stage-major chain: sync_q[0] samples the pads, sync_q[SYNC_STAGES-1] is the safe copy.
  logic [SYNC_STAGES-1:0][NUM_INT-1:0] sync_q;
  logic [NUM_INT-1:0]                  sync_s;
  logic [NUM_INT-1:0]                  filt_s;

  logic [NUM_INT-1:0] prev_q;
  logic [CW-1:0]      cnt_q [NUM_INT];
  logic [CW-1:0]      cnt_d [NUM_INT];
  logic [NUM_INT-1:0] rise;
  logic [NUM_INT-1:0] out_d;
  logic               busy_d;

  assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef INT_SYNC_SRC_FILTER_EN
  localparam int RW = $clog2(FILTER_CYCLES + 1);

  logic [NUM_INT-1:0] filt_q;
  logic [RW-1:0]      run_q [NUM_INT];

  // A line only changes once the synchronised value has disagreed for a full window.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      filt_q <= '0;
      for (int i = 0; i < NUM_INT; i++) run_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_INT; i++) begin
        if (sync_s[i] != filt_q[i]) begin
          if (run_q[i] == RW'(FILTER_CYCLES - 1)) begin
            filt_q[i] <= sync_s[i];
            run_q[i]  <= '0;
          end else begin
            run_q[i]  <= run_q[i] + RW'(1);
          end
        end else begin
          run_q[i] <= '0;
        end
      end
    end
  end

  assign filt_s = filt_q;
`else
  assign filt_s = sync_s;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rise   = '0;
    out_d  = '0;
    cnt_d  = '{default: '0};
    busy_d = 1'b0;
    for (int i = 0; i < NUM_INT; i++) begin
      rise[i] = filt_s[i] & ~prev_q[i];
      if (EDGE_MASK[i]) begin
        if (rise[i])                 cnt_d[i] = PULSE_LOAD;
        else if (cnt_q[i] != '0)     cnt_d[i] = cnt_q[i] - CW'(1);
        else                         cnt_d[i] = cnt_q[i];
        // The rise cycle plus PULSE_CYCLES-1 counted cycles gives exactly PULSE_CYCLES high.
        out_d[i] = rise[i] | (cnt_q[i] > CW'(1));
      end else begin
        out_d[i] = filt_s[i];
      end
      busy_d = busy_d | (cnt_d[i] != '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q        <= '0;
      prev_q        <= '0;
      // NOTE: the counter array is a register file of flops and is reset element by element;
      // a stale count surviving reset would replay a truncated pulse.
      for (int i = 0; i < NUM_INT; i++) cnt_q[i] <= '0;
      auto_out_sync <= '0;
      busy          <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], auto_in};
      prev_q        <= filt_s;
      cnt_q         <= cnt_d;
      auto_out_sync <= out_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_int_sync_crossing_source.sv
// Scoreboard bench for int_sync_crossing_source (default build, filter disabled).
module tb_int_sync_crossing_source;

  localparam int          N  = 4;
  localparam int          SS = 2;
  localparam int          P  = 3;
  localparam logic [N-1:0] EM = 4'b1100;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] auto_in = '1;
  logic [N-1:0] auto_out_sync;
  logic         busy;

  int_sync_crossing_source #(
    .NUM_INT(N), .SYNC_STAGES(SS), .EDGE_MASK(EM), .PULSE_CYCLES(P), .FILTER_CYCLES(3)
  ) dut (
    .clock(clock), .reset(reset), .auto_in(auto_in),
    .auto_out_sync(auto_out_sync), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int           due;
    logic [N-1:0] o;
    logic         b;
  } exp_t;

  exp_t         sb[$];
  logic [N-1:0] hist[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  // Input history starts at all-zero, matching the post-reset synchroniser/edge state.
  task automatic clear_model();
    sb.delete();
    hist.delete();
    for (int i = 0; i <= P; i++) hist.push_back('0);
  endtask

  // Expected output: level bits follow the input; an edge bit is high if any of the
  // last P input samples was a rising edge.
  task automatic apply(input logic [N-1:0] v);
    exp_t e;
    auto_in = v;
    hist.push_back(v);
    if (hist.size() > P + 1) void'(hist.pop_front());
    e.o = v & ~EM;
    for (int b = 0; b < N; b++) begin
      if (EM[b]) begin
        for (int k = 1; k <= P; k++) begin
          logic [N-1:0] cur, prv;
          cur = hist[k];
          prv = hist[k-1];
          if (cur[b] && !prv[b]) e.o[b] = 1'b1;
        end
      end
    end
    e.b   = |(e.o & EM);
    e.due = cyc + SS + 1;
    sb.push_back(e);
  endtask

  task automatic compare_due();
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check("out_sync", 32'(auto_out_sync), 32'(e.o));
      check("busy", 32'(busy), 32'(e.b));
    end
  endtask

  task automatic step(input logic [N-1:0] v);
    @(negedge clock);
    compare_due();
    apply(v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0);
  endtask

  task automatic hold_reset(input int n, input logic [N-1:0] v);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      auto_in = v;
      check("rst_out", 32'(auto_out_sync), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
    end
  endtask

  task automatic release_reset(input logic [N-1:0] v);
    @(negedge clock);
    reset = 1'b1;
    apply(v);
  endtask

  initial begin
    clear_model();
    // Reset held with every line high: nothing may leak out.
    hold_reset(5, 4'hF);
    release_reset('0);
    idle(4);

    // Level line: rise then fall after 10 cycles.
    for (int i = 0; i < 10; i++) step(4'b0001);
    idle(6);

    // Isolated one-cycle edge, then the same line held high.
    step(4'b0100);
    idle(6);
    for (int i = 0; i < 20; i++) step(4'b0100);
    idle(6);

    // Retrigger two cycles apart, then simultaneous rises on both edge lines.
    step(4'b1000); step(4'b0000); step(4'b1000);
    idle(7);
    step(4'b1100);
    idle(6);
    step(4'b1101); step(4'b0001); step(4'b0101);
    idle(6);

    // Random mix of all lines.
    for (int i = 0; i < 40; i++) step(4'($urandom_range(0, 15)));
    idle(6);

    // Reset during the second high cycle of a pulse.
    step(4'b0100);
    idle(4);
    #2 reset = 1'b0;
    #1;
    check("midrst_out", 32'(auto_out_sync), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    clear_model();
    hold_reset(3, '0);
    release_reset('0);
    idle(8);

    // Edge line high across reset release: exactly one pulse.
    @(negedge clock);
    reset = 1'b0;
    clear_model();
    hold_reset(3, 4'b0100);
    release_reset(4'b0100);
    for (int i = 0; i < 10; i++) step(4'b0100);
    idle(6);

    check("sb_drained_pending", 32'(sb.size() > SS + 1), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
